posit_sign_apply_pipe: RTL

POSIT_SIGN_APPLY_PIPE -- requirements
Module: posit_sign_apply_pipe

---
 rtl/posit_sign_apply_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/posit_sign_apply_pipe.sv
// Applies per-lane posit sign (two's complement) and optional NaR override, then buffers in a main+skid pair.
// Latency: 1 cycle from input acceptance to out_vld. Optional NaR handling: define POSIT_SIGN_APPLY_NAR_EN.
// Backpressure: in_rdy is registered and drops only when both main and skid entries are occupied.

package posit_pkg;
    localparam int FULL_L = 32;
endpackage

package pe_pkg;
    localparam int PRECISION_CONFIG_L = 2;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_32B = 2'd0;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_16B = 2'd1;
    localparam logic [PRECISION_CONFIG_L-1:0] PRECISION_CONFIG_8B  = 2'd2;
endpackage

module posit_sign_apply_pipe #(
    parameter int CNT_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [posit_pkg::FULL_L-1:0]          in_data,
    input  logic [3:0]                            in_sign,
    input  logic [3:0]                            in_nar,
    input  logic [pe_pkg::PRECISION_CONFIG_L-1:0] in_mode,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    output logic [posit_pkg::FULL_L-1:0]          out_data,
    output logic [pe_pkg::PRECISION_CONFIG_L-1:0] out_mode,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic [CNT_W-1:0]                      out_cnt
);

    localparam int FL = posit_pkg::FULL_L;
    localparam int ML = pe_pkg::PRECISION_CONFIG_L;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            rdy_q;
    logic            in_xfer;
    logic            out_xfer;
    logic [FL-1:0]   proc_dat;
    logic [FL-1:0]   main_dat_q;
    logic [FL-1:0]   skid_dat_q;
    logic [ML-1:0]   main_mode_q;
    logic [ML-1:0]   skid_mode_q;
    logic [CNT_W-1:0] cnt_q;

    assign in_xfer  = in_vld & rdy_q;
    assign out_xfer = out_vld & out_rdy;

    // Negation is confined to each lane slice, so carries never cross lane boundaries
    // and a zero lane negates to zero on its own.
    always_comb begin
        proc_dat = in_data;
        case (in_mode)
            pe_pkg::PRECISION_CONFIG_32B: begin
                if (in_sign[0]) proc_dat = ~in_data + 32'd1;
            end
            pe_pkg::PRECISION_CONFIG_16B: begin
                for (int i = 0; i < 2; i++) begin
                    if (in_sign[i]) proc_dat[i*16 +: 16] = ~in_data[i*16 +: 16] + 16'd1;
                end
            end
            pe_pkg::PRECISION_CONFIG_8B: begin
                for (int i = 0; i < 4; i++) begin
                    if (in_sign[i]) proc_dat[i*8 +: 8] = ~in_data[i*8 +: 8] + 8'd1;
                end
            end
            default: ;
        endcase
`ifdef POSIT_SIGN_APPLY_NAR_EN
        case (in_mode)
            pe_pkg::PRECISION_CONFIG_32B: begin
                if (in_nar[0]) proc_dat = 32'h8000_0000;
            end
            pe_pkg::PRECISION_CONFIG_16B: begin
                for (int i = 0; i < 2; i++) begin
                    if (in_nar[i]) proc_dat[i*16 +: 16] = 16'h8000;
                end
            end
            pe_pkg::PRECISION_CONFIG_8B: begin
                for (int i = 0; i < 4; i++) begin
                    if (in_nar[i]) proc_dat[i*8 +: 8] = 8'h80;
                end
            end
            default: ;
        endcase
`endif
    end

`ifndef POSIT_SIGN_APPLY_NAR_EN
    logic unused_nar;
    assign unused_nar = ^in_nar;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != S_TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (in_xfer) state_d = S_ONE;
            S_ONE: begin
                if (in_xfer && !out_xfer)      state_d = S_TWO;
                else if (!in_xfer && out_xfer) state_d = S_EMPTY;
            end
            S_TWO:   if (out_xfer) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        out_vld = (state_q == S_ONE) || (state_q == S_TWO);
    end

    assign in_rdy   = rdy_q;
    assign out_data = main_dat_q;
    assign out_mode = main_mode_q;
    assign out_cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_dat_q  <= '0;
            main_mode_q <= '0;
            skid_dat_q  <= '0;
            skid_mode_q <= '0;
            cnt_q       <= '0;
        end else begin
            if (in_xfer) cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                S_EMPTY: begin
                    if (in_xfer) begin
                        main_dat_q  <= proc_dat;
                        main_mode_q <= in_mode;
                    end
                end
                S_ONE: begin
                    // With both transfers the new word replaces the departing one;
                    // without a drain it parks in the skid slot behind main.
                    if (in_xfer && out_xfer) begin
                        main_dat_q  <= proc_dat;
                        main_mode_q <= in_mode;
                    end else if (in_xfer) begin
                        skid_dat_q  <= proc_dat;
                        skid_mode_q <= in_mode;
                    end
                end
                S_TWO: begin
                    if (out_xfer) begin
                        main_dat_q  <= skid_dat_q;
                        main_mode_q <= skid_mode_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
